reg_file_sb: RTL

//   Parametrised successor to the 32x32 core register file. Adds the following:
//   - registered dual read and single write, with write-to-read bypass
//   - optional hardwired zero register
//   - per-register busy scoreboard for in-flight writebacks
//   - HLT freeze
//   - debug read port
//   - self-clearing FSM that zeroes the array after reset

---
 rtl/rf_pkg.sv | 6 +
 rtl/rf_scoreboard.sv | 32 +++
 rtl/reg_file_sb.sv | 101 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared state encoding and default sizes for the scoreboarded register file
package rf_pkg;
    typedef enum logic [1:0] {RF_CLEAR, RF_RUN, RF_HALT} rf_state_t;
    localparam int RF_DW_DEF = 32;
    localparam int RF_AW_DEF = 5;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for in-flight writebacks
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int AW       = RF_AW_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic [AW-1:0] sr1,
    input  logic [AW-1:0] sr2,
    output logic          nb1,
    output logic          nb2
);
    localparam int NREG = 1 << AW;
    logic [NREG-1:0] busy_q, busy_d;
    // set applied after clear so a new producer wins over a retiring one
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
        nb1 = busy_d[sr1];
        nb2 = busy_d[sr2];
    end
    // busy bit register
    always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: dual-read register file with bypass, busy scoreboard, halt freeze and post-reset clear
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int AW       = RF_AW_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          HLT,
    input  logic          RegW,
    input  logic [AW-1:0] DR,
    input  logic [DW-1:0] Reg_In,
    input  logic          Issue,
    input  logic [AW-1:0] IssueDR,
    input  logic [AW-1:0] SR1,
    input  logic [AW-1:0] SR2,
    output logic [DW-1:0] ReadReg1,
    output logic [DW-1:0] ReadReg2,
    output logic          Busy1,
    output logic          Busy2,
    input  logic [AW-1:0] DbgAddr,
    output logic [DW-1:0] DbgData,
    output logic          Ready
);
    localparam int NREG = 1 << AW;
    rf_state_t state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [DW-1:0] mem_q [NREG];
    logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d, dbg_q, dbg_d, mem_wd, src1, src2;
    logic b1_q, b1_d, b2_q, b2_d, ready_q, ready_d;
    logic run, we, upd, mem_we, nb1, nb2;
    logic [AW-1:0] mem_wa;

    rf_scoreboard #(.AW(AW), .ZERO_REG(ZERO_REG)) u_sb (
        .clk(CLK), .rst(RST),
        .clr_en(RegW && run), .clr_addr(DR),
        .set_en(Issue && run), .set_addr(IssueDR),
        .sr1(SR1), .sr2(SR2), .nb1(nb1), .nb2(nb2)
    );

    // FSM, clear sweep, write port selection, bypass muxes and halt hold
    always_comb begin
        run     = state_q != RF_CLEAR;
        we      = run && RegW && !(ZERO_REG != 0 && DR == '0);
        upd     = run && !HLT;
        state_d = !run ? ((cnt_q == (AW+1)'(NREG-1)) ? RF_RUN : RF_CLEAR)
                       : (HLT ? RF_HALT : RF_RUN);
        cnt_d   = run ? cnt_q : cnt_q + (AW+1)'(1);
        mem_we  = we || !run;
        mem_wa  = run ? DR : cnt_q[AW-1:0];
        mem_wd  = run ? Reg_In : '0;
        src1    = (ZERO_REG != 0 && SR1 == '0) ? '0
                : (BYPASS != 0 && we && DR == SR1) ? Reg_In : mem_q[SR1];
        src2    = (ZERO_REG != 0 && SR2 == '0) ? '0
                : (BYPASS != 0 && we && DR == SR2) ? Reg_In : mem_q[SR2];
        rd1_d   = !run ? '0 : (upd ? src1 : rd1_q);
        rd2_d   = !run ? '0 : (upd ? src2 : rd2_q);
        b1_d    = !run ? 1'b0 : (upd ? nb1 : b1_q);
        b2_d    = !run ? 1'b0 : (upd ? nb2 : b2_q);
        dbg_d   = run ? mem_q[DbgAddr] : '0;
        ready_d = state_d != RF_CLEAR;
    end

    // control and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            b1_q    <= 1'b0;
            b2_q    <= 1'b0;
            dbg_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            dbg_q   <= dbg_d;
            ready_q <= ready_d;
        end
    end

    // storage array; a write coinciding with reset is dropped
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) mem_q[mem_wa] <= mem_wd;
    end

    assign ReadReg1 = rd1_q;
    assign ReadReg2 = rd2_q;
    assign Busy1    = b1_q;
    assign Busy2    = b2_q;
    assign DbgData  = dbg_q;
    assign Ready    = ready_q;
endmodule
